instruction_fetch_unit: RTL and testbench

//   Sequences the combinational program ROM: owns the fetch PC, drives the ROM byte

---
 rtl/instruction_fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, addresses the combinational program ROM and
// buffers {pc, instruction} pairs in a prefetch FIFO. Optional macro: FETCH_STATS_EN.
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fetch_enable,
    input  logic                          redirect_valid,
    input  logic [DATA_WIDTH-1:0]         redirect_pc,
    output logic [DATA_WIDTH-1:0]         rom_address,
    input  logic [DATA_WIDTH-1:0]         rom_instruction,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [DATA_WIDTH-1:0]         instr_out,
    output logic [DATA_WIDTH-1:0]         instr_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]                   fetch_count,
    output logic [31:0]                   stall_count
`endif
);

    localparam int                    PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                    CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]      PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] PC_STEP = {{(DATA_WIDTH-3){1'b0}}, 3'b100};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FULL  = 2'd1,
        ST_PAUSE = 2'd2
    } fetch_state_t;

    logic [DATA_WIDTH-1:0] fetch_pc_r;
    logic [DATA_WIDTH-1:0] mem_instr_r [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_pc_r    [FIFO_DEPTH];
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_nxt_s;
    fetch_state_t          state_r;
    fetch_state_t          state_nxt_s;
    logic                  valid_s;
    logic                  pop_s;
    logic                  push_s;

    assign valid_s     = (count_r != {CNT_W{1'b0}});
    assign rom_address = fetch_pc_r;
    assign instr_valid = valid_s;
    assign fifo_count  = count_r;

    // Handshake: a full FIFO may still accept a push when the head leaves this cycle.
    always_comb begin
        pop_s  = valid_s & instr_ready;
        push_s = fetch_enable & ((count_r < DEPTH_C) | pop_s) & ~redirect_valid;
    end

    // Next occupancy; a redirect empties the FIFO and swallows any concurrent pop.
    always_comb begin
        count_nxt_s = count_r;
        if (redirect_valid) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Fetch state tracking: redirect, then pause, then fullness decide the next state.
    always_comb begin
        state_nxt_s = state_r;
        if (redirect_valid) begin
            state_nxt_s = ST_RUN;
        end else if (!fetch_enable) begin
            state_nxt_s = ST_PAUSE;
        end else begin
            case (state_r)
                ST_RUN, ST_PAUSE, ST_FULL: begin
                    if ((count_nxt_s == DEPTH_C) && !pop_s) begin
                        state_nxt_s = ST_FULL;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                default: state_nxt_s = ST_RUN;
            endcase
        end
    end

    // Control state: PC, pointers, occupancy and FSM register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            state_r    <= ST_RUN;
        end else begin
            count_r <= count_nxt_s;
            state_r <= state_nxt_s;
            if (redirect_valid) begin
                fetch_pc_r <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
                head_r     <= {PTR_W{1'b0}};
                tail_r     <= {PTR_W{1'b0}};
            end else begin
                if (push_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                    tail_r     <= tail_r + PTR_ONE;
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_ONE;
                end
            end
        end
    end

    // FIFO storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_instr_r[tail_r] <= rom_instruction;
            mem_pc_r[tail_r]    <= fetch_pc_r;
        end
    end

    // Head presentation, zero when nothing is valid.
    always_comb begin
        instr_out = {DATA_WIDTH{1'b0}};
        instr_pc  = {DATA_WIDTH{1'b0}};
        if (valid_s) begin
            instr_out = mem_instr_r[head_r];
            instr_pc  = mem_pc_r[head_r];
        end else begin
            instr_out = {DATA_WIDTH{1'b0}};
            instr_pc  = {DATA_WIDTH{1'b0}};
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_r;
    logic [31:0] stall_count_r;

    // Stall means fetch was wanted but blocked by a full FIFO; pauses and redirects excluded.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_r <= 32'd0;
            stall_count_r <= 32'd0;
        end else begin
            if (push_s) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end
            if (fetch_enable && !push_s && !redirect_valid) begin
                stall_count_r <= stall_count_r + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_r;
    assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit (DATA_WIDTH=32, FIFO_DEPTH=4).
module tb_instruction_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] rom_address;
    logic [31:0] rom_instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [2:0]  fifo_count;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    // ROM model: word differs from its address so pc/instruction swaps are visible.
    assign rom_instruction = rom_address ^ KEY;

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_enable    (fetch_enable),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .rom_address     (rom_address),
        .rom_instruction (rom_instruction),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .fifo_count      (fifo_count)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; fetch_enable = 1'b1; redirect_valid = 1'b0;
        redirect_pc = 32'd0; instr_ready = 1'b1;
        repeat (3) step();
        check_eq("rst_count", {29'd0, fifo_count}, 32'd0);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_romaddr", rom_address, RPC);
        check_eq("rst_iout", instr_out, 32'd0);
        check_eq("rst_ipc", instr_pc, 32'd0);

        // 1: streaming with ready high
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t1_valid", {31'd0, instr_valid}, 32'd1);
            check_eq("t1_pc", instr_pc, RPC + 32'(4 * i));
            check_eq("t1_instr", instr_out, (RPC + 32'(4 * i)) ^ KEY);
            check_eq("t1_count", {29'd0, fifo_count}, 32'd1);
        end

        // 2: fill with ready low
        reset = 1'b1; step();
        reset = 1'b0; instr_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            check_eq("t2_count", {29'd0, fifo_count}, (i < 4) ? 32'(i) : 32'd4);
            check_eq("t2_romaddr", rom_address, RPC + 32'(4 * ((i < 4) ? i : 4)));
            check_eq("t2_hold_pc", instr_pc, RPC);
        end

        // 3: full with pop and push together, continuous sequence
        instr_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_eq("t3_count", {29'd0, fifo_count}, 32'd4);
            check_eq("t3_pc", instr_pc, RPC + 32'(4 * k));
            check_eq("t3_romaddr", rom_address, RPC + 32'h10 + 32'(4 * k));
        end

        // 4: redirect with three entries queued
        reset = 1'b1; step();
        reset = 1'b0; instr_ready = 1'b0;
        repeat (3) step();
        check_eq("t4_pre_count", {29'd0, fifo_count}, 32'd3);
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
        step();
        redirect_valid = 1'b0;
        check_eq("t4_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("t4_count", {29'd0, fifo_count}, 32'd0);
        check_eq("t4_romaddr", rom_address, 32'h0040_0100);
        step();
        check_eq("t4_pc", instr_pc, 32'h0040_0100);
        check_eq("t4_instr", instr_out, 32'h0040_0100 ^ KEY);

        // 5: reset mid-stream at count 2
        instr_ready = 1'b0;
        step();
        check_eq("t5_pre_count", {29'd0, fifo_count}, 32'd2);
        reset = 1'b1;
        step();
        check_eq("t5_count", {29'd0, fifo_count}, 32'd0);
        check_eq("t5_romaddr", rom_address, RPC);
        check_eq("t5_valid", {31'd0, instr_valid}, 32'd0);
        reset = 1'b0; instr_ready = 1'b1;

        // 6: pause keeps the PC
        fetch_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t6_romaddr", rom_address, RPC);
            check_eq("t6_count", {29'd0, fifo_count}, 32'd0);
        end
`ifdef FETCH_STATS_EN
        check_eq("t6_stall_paused", stall_count, 32'd0);
`endif
        fetch_enable = 1'b1;
        repeat (8) step();
        check_eq("t6_romaddr_run", rom_address, RPC + 32'h20);
`ifdef FETCH_STATS_EN
        check_eq("t6_fetch8", fetch_count, 32'd8);
        check_eq("t6_stall0", stall_count, 32'd0);
        instr_ready = 1'b0;
        repeat (6) step();
        check_eq("t6_fetch11", fetch_count, 32'd11);
        check_eq("t6_stall3", stall_count, 32'd3);
        instr_ready = 1'b1;
`endif

        // Wrap: PC increments modulo 2^32, unaligned target forced to word
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        check_eq("wrap_target", rom_address, 32'hFFFF_FFFC);
        step();
        check_eq("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check_eq("wrap_romaddr", rom_address, 32'h0000_0000);
        step();
        check_eq("wrap_next_pc", instr_pc, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
